// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================
// Package  : clk_mon_pkg
// Brief    : Shared types and defaults for divided-clock checkers.
// Revision : 1.0
// ============================================================
package clk_mon_pkg;

  localparam int CLK_MON_CNT_W    = 8;
  localparam int CLK_MON_LOCK_CNT = 4;

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2
  } clk_mon_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================
// Module   : edge_detect
// Brief    : Previous-sample register with rise/fall strobes and pulses.
// Revision : 1.0
// ============================================================
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise_now,
  output logic fall_now,
  output logic rise,
  output logic fall
);

  logic r_prev;

  assign rise_now = din & ~r_prev;
  assign fall_now = ~din & r_prev;

  // prev tracks the input even in reset so a clean 0->1 at release is a rise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prev <= din;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_prev <= din;
      rise   <= rise_now;
      fall   <= fall_now;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================
// Module   : clk_div_monitor
// Brief    : Measures high/low phases of a divided clock against an even ratio.
// Revision : 1.0
// ============================================================
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = CLK_MON_CNT_W,
  parameter int LOCK_CNT = CLK_MON_LOCK_CNT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_in,
  input  logic [CNT_W-1:0] ratio,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err
);

  localparam int                  c_GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [c_GOOD_W-1:0] c_GOOD_MAX = c_GOOD_W'(LOCK_CNT);
  localparam logic [c_GOOD_W-1:0] c_GOOD_ONE = c_GOOD_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    c_RATIO_MIN = CNT_W'(2);

  clk_mon_state_t      r_state;
  logic [CNT_W-1:0]    r_hi_cnt;
  logic [CNT_W-1:0]    r_lo_cnt;
  logic [CNT_W-1:0]    r_ratio_q;
  logic [c_GOOD_W-1:0] r_good_cnt;

  logic                w_rise;
  logic                w_fall;
  logic                w_ratio_bad;
  logic                w_phases_match;
  logic [CNT_W-1:0]    w_half;
  logic [c_GOOD_W-1:0] w_good_base;
  logic [c_GOOD_W-1:0] w_good_next;

  edge_detect u_edge (
    .clk      (clk),
    .resetn   (resetn),
    .din      (div_in),
    .rise_now (w_rise),
    .fall_now (w_fall),
    .rise     (rise),
    .fall     (fall)
  );

  assign w_half         = r_ratio_q >> 1;
  assign w_ratio_bad    = ratio[0] | (ratio < c_RATIO_MIN);
  assign w_phases_match = (r_hi_cnt == w_half) && (r_lo_cnt == w_half);

  // A clear in the same cycle as a good period restarts the count from that period
  assign w_good_base = clr ? '0 : r_good_cnt;
  assign w_good_next = (w_good_base == c_GOOD_MAX) ? c_GOOD_MAX : (w_good_base + c_GOOD_ONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_WAIT_RISE;
      r_hi_cnt   <= '0;
      r_lo_cnt   <= '0;
      r_ratio_q  <= '0;
      r_good_cnt <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      period_vld <= 1'b0;

      // Error events below are assigned later and therefore win over clr
      if (clr) begin
        err        <= 1'b0;
        locked     <= 1'b0;
        r_good_cnt <= '0;
      end

      case (r_state)
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_ratio_q <= ratio;
            r_hi_cnt  <= c_CNT_ONE;
            if (w_ratio_bad) begin
              err        <= 1'b1;
              locked     <= 1'b0;
              r_good_cnt <= '0;
            end else begin
              r_state <= ST_HIGH;
            end
          end
        end

        ST_HIGH: begin
          if (w_fall) begin
            r_lo_cnt <= c_CNT_ONE;
            r_state  <= ST_LOW;
          end else if (r_hi_cnt >= w_half) begin
            err        <= 1'b1;
            locked     <= 1'b0;
            r_good_cnt <= '0;
            r_state    <= ST_WAIT_RISE;
          end else begin
            r_hi_cnt <= r_hi_cnt + c_CNT_ONE;
          end
        end

        ST_LOW: begin
          if (w_rise) begin
            period     <= r_hi_cnt + r_lo_cnt;
            period_vld <= 1'b1;
            r_ratio_q  <= ratio;
            r_hi_cnt   <= c_CNT_ONE;
            if (w_ratio_bad) begin
              err        <= 1'b1;
              locked     <= 1'b0;
              r_good_cnt <= '0;
              r_state    <= ST_WAIT_RISE;
            end else if (w_phases_match) begin
              r_good_cnt <= w_good_next;
              locked     <= (w_good_next == c_GOOD_MAX);
              r_state    <= ST_HIGH;
            end else begin
              err        <= 1'b1;
              locked     <= 1'b0;
              r_good_cnt <= '0;
              r_state    <= ST_HIGH;
            end
          end else if (r_lo_cnt >= w_half) begin
            err        <= 1'b1;
            locked     <= 1'b0;
            r_good_cnt <= '0;
            r_state    <= ST_WAIT_RISE;
          end else begin
            r_lo_cnt <= r_lo_cnt + c_CNT_ONE;
          end
        end

        default: r_state <= ST_WAIT_RISE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================
// Module   : tb_clk_div_monitor
// Brief    : Scoreboard bench for clk_div_monitor against a phase-length model.
// Revision : 1.0
// ============================================================
`timescale 1ns/1ps
module tb_clk_div_monitor;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             div_in = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] ratio = 8'd2;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_in     (div_in),
    .ratio      (ratio),
    .clr        (clr),
    .rise       (rise),
    .fall       (fall),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rise;
    logic             fall;
    logic             pv;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             err;
  } obs_t;

  obs_t exp_q[$];
  int   per_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ratio_nxt = 2;

  // Reference model: phase run lengths measured from the sampled waveform
  bit m_prev = 1'b0;
  bit m_measuring = 1'b0;
  bit m_in_high = 1'b0;
  int m_high_len = 0;
  int m_low_len = 0;
  int m_half = 0;
  int m_good = 0;
  int e_period = 0;
  bit e_lock = 1'b0;
  bit e_err = 1'b0;

  function automatic bit ratio_illegal(input int r);
    return (r % 2 != 0) || (r < 2);
  endfunction

  task automatic model_fault();
    e_err  = 1'b1;
    e_lock = 1'b0;
    m_good = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit rn, input int rat, output obs_t o);
    bit r, f, pv, ok;
    r  = s && !m_prev;
    f  = !s && m_prev;
    pv = 1'b0;
    m_prev = s;
    if (!rn) begin
      r = 1'b0; f = 1'b0;
      m_measuring = 1'b0; m_good = 0; e_period = 0; e_lock = 1'b0; e_err = 1'b0;
    end else begin
      if (c) begin e_err = 1'b0; e_lock = 1'b0; m_good = 0; end
      if (!m_measuring) begin
        if (r) begin
          m_half = rat / 2;
          if (ratio_illegal(rat)) model_fault();
          else begin m_measuring = 1'b1; m_in_high = 1'b1; m_high_len = 1; end
        end
      end else if (m_in_high) begin
        if (!s) begin m_in_high = 1'b0; m_low_len = 1; end
        else if (m_high_len + 1 > m_half) begin model_fault(); m_measuring = 1'b0; end
        else m_high_len++;
      end else begin
        if (s) begin
          pv = 1'b1;
          e_period = m_high_len + m_low_len;
          ok = (m_high_len == m_half) && (m_low_len == m_half);
          m_half = rat / 2; m_high_len = 1; m_in_high = 1'b1;
          if (ratio_illegal(rat)) begin model_fault(); m_measuring = 1'b0; end
          else if (ok) begin
            m_good = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
            e_lock = (m_good == LOCK_CNT);
          end else model_fault();
        end else if (m_low_len + 1 > m_half) begin model_fault(); m_measuring = 1'b0; end
        else m_low_len++;
      end
    end
    o.rise = r; o.fall = f; o.pv = pv; o.period = e_period[CNT_W-1:0];
    o.locked = e_lock; o.err = e_err;
  endtask

  task automatic step(input bit s, input bit c, input bit rn);
    obs_t o;
    @(negedge clk);
    div_in = s; clr = c; resetn = rn; ratio = ratio_nxt[CNT_W-1:0];
    model_step(s, c, rn, ratio_nxt, o);
    exp_q.push_back(o);
    if (o.pv) per_q.push_back(int'(o.period));
  endtask

  task automatic wave(input int hi, input int lo, input int clr_pct);
    for (int i = 0; i < hi; i++) step(1'b1, int'($urandom_range(0, 99)) < clr_pct, 1'b1);
    for (int i = 0; i < lo; i++) step(1'b0, int'($urandom_range(0, 99)) < clr_pct, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare every registered output cycle and every period event
  initial begin
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {rise, fall, period_vld, period, locked, err};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs at %0t: got rise=%b fall=%b vld=%b period=%0d locked=%b err=%b expected rise=%b fall=%b vld=%b period=%0d locked=%b err=%b",
                   $time, a.rise, a.fall, a.pv, a.period, a.locked, a.err,
                   e.rise, e.fall, e.pv, e.period, e.locked, e.err);
        end
        if (period_vld === 1'b1) begin
          n_checks++;
          if (per_q.size() == 0) begin
            n_fail++;
            $display("FAIL period_event: got period_vld with period=%0d expected no event", period);
          end else begin
            int p;
            p = per_q.pop_front();
            if (int'(period) != p) begin
              n_fail++;
              $display("FAIL period_value: got %0d expected %0d", period, p);
            end
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, hi, lo;
    // Reset state
    ratio_nxt = 2;
    do_reset(3);
    settle();
    chk("reset_state", 16'({rise, fall, period_vld, locked, err, period}), 16'd0);

    // div2 lock
    for (int i = 0; i < 10; i++) wave(1, 1, 0);
    settle();
    chk("div2_lock_err", 16'({locked, err}), 16'b10);
    chk("div2_period", 16'(period), 16'd2);

    // div6 lock
    ratio_nxt = 6;
    do_reset(3);
    for (int i = 0; i < 6; i++) wave(3, 3, 0);
    settle();
    chk("div6_lock_err", 16'({locked, err}), 16'b10);
    chk("div6_period", 16'(period), 16'd6);

    // Short high phase: low run overruns half
    ratio_nxt = 4;
    do_reset(3);
    for (int i = 0; i < 5; i++) wave(2, 2, 0);
    wave(1, 3, 0);
    settle();
    chk("short_phase_err", 16'({locked, err}), 16'b01);
    wave(2, 2, 0);
    wave(2, 2, 0);
    wave(2, 2, 100);
    for (int i = 0; i < 4; i++) wave(2, 2, 0);
    settle();
    chk("relock_after_clr", 16'({locked, err}), 16'b10);

    // Stuck-high input
    do_reset(3);
    for (int i = 0; i < 3; i++) wave(2, 2, 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    settle();
    chk("stuck_2nd_high", 16'(err), 16'd0);
    step(1'b1, 1'b0, 1'b1);
    settle();
    chk("stuck_3rd_high", 16'({locked, err}), 16'b01);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    wave(0, 2, 0);

    // Reset during a high phase of a locked stream
    do_reset(3);
    for (int i = 0; i < 6; i++) wave(2, 2, 0);
    step(1'b1, 1'b0, 1'b1);
    do_reset(3);
    settle();
    chk("mid_reset_outputs", 16'({rise, fall, period_vld, locked, err, period}), 16'd0);
    for (int i = 0; i < 6; i++) wave(2, 2, 0);
    settle();
    chk("after_reset_relock", 16'({locked, err, period}), 16'({2'b10, 8'd4}));

    // Illegal ratio at first rise
    ratio_nxt = 5;
    do_reset(3);
    for (int i = 0; i < 3; i++) wave(3, 2, 0);
    settle();
    chk("illegal_ratio_err", 16'({locked, err}), 16'b01);

    // Randomised streams with jitter, clears and occasional ratio changes
    for (int seg = 0; seg < 8; seg++) begin
      ratio_nxt = 2 * int'($urandom_range(1, 6));
      do_reset(2);
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 19) == 0) ratio_nxt = 2 * int'($urandom_range(1, 6));
        h  = ratio_nxt / 2;
        hi = h;
        lo = h;
        if ($urandom_range(0, 7) == 0) hi = ($urandom_range(0, 1) == 1) ? h + 1 : ((h > 1) ? h - 1 : 1);
        if ($urandom_range(0, 7) == 0) lo = ($urandom_range(0, 1) == 1) ? h + 1 : ((h > 1) ? h - 1 : 1);
        if ($urandom_range(0, 29) == 0) hi = h + 3;
        wave(hi, lo, 6);
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    settle();
    settle();
    chk("pending_period_events", 16'(per_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
